// File: rtl/counter_checker_pkg.sv
// Shared encodings for the counter checker and its golden model.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package counter_checker_pkg;

    // Counter mode encodings, shared with the Counter being checked
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP3  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Checker FSM encodings
    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_FAIL  = 2'd2;

endpackage

// File: rtl/counter_checker_model.sv
// Golden next-state function of the 4-mode counter: (q, enb, modo, data) -> (next_q, next_rco).
// Latency: purely combinational.
// Backpressure: none; pure function with no handshake.
module counter_model
    import counter_checker_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] next_q,
    output logic             next_rco
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH:0] sum3;

    // Next count and carry; disabled counter holds with rco low in every mode
    always_comb begin
        sum3     = {1'b0, q} + (WIDTH+1)'(3);
        next_q   = q;
        next_rco = 1'b0;
        if (enb) begin
            case (modo)
                MODE_UP: begin
                    next_q   = q + ONE;
                    next_rco = (q == ALL_ONES);
                end
                MODE_DOWN: begin
                    next_q   = q - ONE;
                    next_rco = (q == '0);
                end
                MODE_UP3: begin
                    next_q   = sum3[WIDTH-1:0];
                    next_rco = sum3[WIDTH];
                end
                default: begin
                    next_q   = data;
                    next_rco = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Lockstep monitor of the 4-bit Counter: golden model, comparator, error/check counters, sticky fail.
// Latency: err pulses 1 cycle after a wrong Q/rco appears; exp_q tracks the DUT with zero lag.
// Backpressure: none; passive snooper that never stalls the DUT or its stimulus.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 8,
    parameter int MAX_ERR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] Q,
    input  logic             rco,
    output logic [WIDTH-1:0] exp_q,
    output logic             err,
    output logic             fail,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count
);

    localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] exp_q_q,     exp_q_d;
    logic             exp_rco_q,   exp_rco_d;
    logic             err_q,       err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] chk_count_q, chk_count_d;

    logic [WIDTH-1:0] model_q;
    logic             model_rco;
    logic             compare_en;
    logic             mismatch;
    logic [CNT_W-1:0] err_inc;

    // The model advances from its own expected state, so a single DUT glitch
    // costs one error and does not derail the following comparisons.
    counter_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .q        (exp_q_q),
        .enb      (enb),
        .modo     (modo),
        .data     (data),
        .next_q   (model_q),
        .next_rco (model_rco)
    );

    // Compare, count, advance model and step the FSM
    always_comb begin
        state_d     = state_q;
        exp_q_d     = model_q;
        exp_rco_d   = model_rco;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        chk_count_d = chk_count_q;
        err_inc     = err_count_q + CNT_ONE;
        compare_en  = (state_q == S_CHECK) || (state_q == S_FAIL);
        mismatch    = compare_en && ((Q != exp_q_q) || (rco != exp_rco_q));

        if (compare_en && (chk_count_q != CNT_MAX)) begin
            chk_count_d = chk_count_q + CNT_ONE;
        end

        if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
                err_count_d = err_inc;
            end
            if ((state_q == S_CHECK) && (err_inc == MAX_ERR_C)) begin
                state_d = S_FAIL;
            end
        end

        // The release edge only primes the model; an unused encoding recovers via S_RST
        case (state_q)
            S_RST:   state_d = S_CHECK;
            S_CHECK,
            S_FAIL:  ;
            default: state_d = S_RST;
        endcase
    end

    // State registers with synchronous active-low reset; reset beats any mismatch
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_RST;
            exp_q_q     <= '0;
            exp_rco_q   <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            chk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q_q     <= exp_q_d;
            exp_rco_q   <= exp_rco_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            chk_count_q <= chk_count_d;
        end
    end

    assign exp_q     = exp_q_q;
    assign err       = err_q;
    assign fail      = (state_q == S_FAIL);
    assign err_count = err_count_q;
    assign chk_count = chk_count_q;

endmodule
